// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources; registered output, 1-cycle latency.
// Losers see ready=0 and hold their request; stall_i/rst block all grants. WBARB_PERF_EN adds per-requester handshake counters.
module regfile_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int DW    = 64,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*AW-1:0]   req_waddr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  input  logic                 stall_i,
  output logic                 we_o,
  output logic [AW-1:0]        waddr_o,
  output logic [DW-1:0]        wdata_o,
  output logic                 busy_o
`ifdef WBARB_PERF_EN
  ,
  output logic [NREQ*CNT_W-1:0] perf_cnt_o
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          hs;
  logic [AW-1:0] sel_waddr;
  logic [DW-1:0] sel_wdata;

  // Search starts at rr_ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_found && !stall_i && !rst) req_ready_o[grant_idx] = 1'b1;
  end

  assign hs        = |(req_valid_i & req_ready_o);
  assign sel_waddr = req_waddr_i[grant_idx*AW +: AW];
  assign sel_wdata = req_wdata_i[grant_idx*DW +: DW];

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      rr_ptr  <= '0;
    end else begin
      we_o <= hs && (sel_waddr != '0);
      if (hs) begin
        waddr_o <= sel_waddr;
        wdata_o <= sel_wdata;
        rr_ptr  <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end

  assign busy_o = (|req_valid_i) | we_o;

`ifdef WBARB_PERF_EN
  logic [CNT_W-1:0] cnt [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid_i[i] && req_ready_o[i]) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    assign perf_cnt_o[g*CNT_W +: CNT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (NREQ=3, DW=64, AW=5, CNT_W=4).
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3, DW = 64, AW = 5, CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_waddr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic                stall;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;
  logic                busy;
`ifdef WBARB_PERF_EN
  logic [NREQ*CNT_W-1:0] perf_cnt;
`endif

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_waddr_i (req_waddr),
    .req_wdata_i (req_wdata),
    .stall_i     (stall),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .busy_o      (busy)
`ifdef WBARB_PERF_EN
    ,
    .perf_cnt_o  (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        busy;
  } vec_t;

  vec_t vecs[19];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for one cycle; expected ready (same cycle) and registered outputs from the previous edge.
    // Table-phase requesters: req0 addr 3 data 103, req1 addr 7 data 207, req2 addr 9 data 309.
    vecs[0]  = '{1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 5'd0, 64'h0,   1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 5'd0, 64'h0,   1'b1};
    vecs[2]  = '{1'b0, 1'b0, 3'b111, 3'b001, 1'b0, 5'd0, 64'h0,   1'b1};
    vecs[3]  = '{1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 5'd3, 64'h103, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 5'd7, 64'h207, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 5'd9, 64'h309, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 5'd3, 64'h103, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 5'd7, 64'h207, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 5'd9, 64'h309, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 5'd9, 64'h309, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'b110, 3'b010, 1'b0, 5'd9, 64'h309, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 3'b101, 3'b100, 1'b1, 5'd7, 64'h207, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 3'b101, 3'b001, 1'b1, 5'd9, 64'h309, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 3'b100, 3'b100, 1'b1, 5'd3, 64'h103, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 3'b110, 3'b000, 1'b1, 5'd9, 64'h309, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 3'b110, 3'b010, 1'b0, 5'd9, 64'h309, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 3'b011, 3'b001, 1'b1, 5'd7, 64'h207, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 5'd3, 64'h103, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 5'd0, 64'h0,   1'b0};

    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = '0;
    req_waddr = {5'd9, 5'd7, 5'd3};
    req_wdata = {64'h309, 64'h207, 64'h103};
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      rst       = vecs[i].rst;
      stall     = vecs[i].stall;
      req_valid = vecs[i].valid;
      @(negedge clk);
      check($sformatf("row%0d ready", i), 64'(req_ready), 64'(vecs[i].ready));
      check($sformatf("row%0d we",    i), 64'(we),        64'(vecs[i].we));
      check($sformatf("row%0d waddr", i), 64'(waddr),     64'(vecs[i].waddr));
      check($sformatf("row%0d wdata", i), wdata,          vecs[i].wdata);
      check($sformatf("row%0d busy",  i), 64'(busy),      64'(vecs[i].busy));
      next_cycle();
    end

    // Single requester, one-cycle write latency (rr_ptr is 0 here).
    req_valid         = 3'b010;
    req_waddr[5 +: 5] = 5'd7;
    req_wdata[64 +: 64] = 64'hDEAD_BEEF;
    @(negedge clk);
    check("solo ready", 64'(req_ready), 64'(3'b010));
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("solo we",    64'(we),    64'h1);
    check("solo waddr", 64'(waddr), 64'd7);
    check("solo wdata", wdata,      64'hDEAD_BEEF);
    next_cycle();

    // x0 write: accepted, address/data load, no write enable.
    req_valid         = 3'b001;
    req_waddr[0 +: 5] = 5'd0;
    req_wdata[0 +: 64] = 64'h1;
    @(negedge clk);
    check("x0 ready", 64'(req_ready), 64'(3'b001));
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("x0 we",    64'(we),    64'h0);
    check("x0 waddr", 64'(waddr), 64'd0);
    check("x0 wdata", wdata,      64'h1);
    next_cycle();

    // Stall holds off req2 for three cycles.
    req_valid = 3'b100;
    stall     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d ready", c), 64'(req_ready), 64'h0);
      check($sformatf("stall%0d we",    c), 64'(we),        64'h0);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall ready", 64'(req_ready), 64'(3'b100));
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("unstall we",    64'(we),    64'h1);
    check("unstall waddr", 64'(waddr), 64'd9);
    check("unstall wdata", wdata,      64'h309);
    next_cycle();

`ifdef WBARB_PERF_EN
    rst = 1'b1;
    next_cycle();
    rst               = 1'b0;
    req_waddr[0 +: 5] = 5'd3;
    req_valid         = 3'b001;
    repeat (17) next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("perf cnt0 wrap", 64'(perf_cnt[3:0]),  64'd1);
    check("perf cnt1",      64'(perf_cnt[7:4]),  64'd0);
    check("perf cnt2",      64'(perf_cnt[11:8]), 64'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("perf after rst", 64'(perf_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
